// File: rtl/handshake_pkg.sv
// Shared types and constants for the handshake slave.
// Used by handshake_fifo and handshake_slave.
package handshake_pkg;

  localparam int DEFAULT_DATA_BITS = 8;
  localparam int COUNT_BITS        = 16;

  typedef logic [COUNT_BITS-1:0] beat_count_t;

  function automatic int ptr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/handshake_fifo.sv
// Receive FIFO: power-of-two depth, pointers wrap naturally.
// Storage is not reset; only pointers and occupancy are.
module handshake_fifo
  import handshake_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = ptr_bits(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wp;
  logic [AW-1:0]        rp;
  logic [AW:0]          cnt;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/handshake_slave.sv
// Valid/ready slave feeding a receive FIFO, with beat/overflow status.
// Define HANDSHAKE_SLAVE_PROTOCOL_CHECK_EN to build the protocol checker.
module handshake_slave
  import handshake_pkg::*;
#(
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int ALWAYS_READY = 0,
  parameter int DEPTH        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output beat_count_t          beat_count,
  output logic                 overflow,
  output logic                 protocol_err
);

  logic full;
  logic empty;
  logic xfer;
  logic pop;
  logic wr;

  assign xfer      = valid & ready;
  assign pop       = out_ready & ~empty;
  assign wr        = xfer & (~full | pop);
  assign out_valid = ~empty;

  handshake_fifo #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr),
    .wdata (data),
    .pop   (pop),
    .rdata (out_data),
    .full  (full),
    .empty (empty)
  );

  generate
    if (ALWAYS_READY != 0) begin : g_rdy_reg
      logic rdy_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdy_q <= 1'b0;
        else      rdy_q <= 1'b1;
      end
      assign ready = rdy_q;
    end else begin : g_rdy_comb
      // Gated by reset so ready drops the instant reset asserts
      assign ready = rst & ~full;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (xfer) beat_count <= beat_count + 1'b1;
      if (xfer & full & ~pop) overflow <= 1'b1;
    end
  end

`ifdef HANDSHAKE_SLAVE_PROTOCOL_CHECK_EN
  logic                 pend;
  logic [DATA_BITS-1:0] pdata;
  logic                 perr;

  // A stalled beat must stay offered, unchanged, until accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend  <= 1'b0;
      pdata <= '0;
      perr  <= 1'b0;
    end else begin
      if (pend & (~valid | (data != pdata))) perr <= 1'b1;
      pend  <= valid & ~ready;
      pdata <= data;
    end
  end

  assign protocol_err = perr;
`else
  assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_handshake_slave.sv
// Scoreboard bench: one combinational-ready and one registered-ready
// instance, each checked against a queue model at every falling edge.
module tb_handshake_slave;

`ifdef HANDSHAKE_SLAVE_PROTOCOL_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic        clk;
  logic        rst;

  logic        v0, ready0, ov0, ordy0, ovf0, err0;
  logic [7:0]  dt0, od0;
  logic [15:0] bcnt0;

  logic        v1, ready1, ov1, ordy1, ovf1, err1;
  logic [7:0]  dt1, od1;
  logic [15:0] bcnt1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [15:0] bc0, bc1;
  logic        ovf1e, perr0, perr1, pend0, pend1, seen1;
  logic [7:0]  pd0, pd1;
  int          npop0, npop1;

  handshake_slave #(
    .DATA_BITS(8), .ALWAYS_READY(0), .DEPTH(4)
  ) u_dut0 (
    .clk(clk), .rst(rst), .valid(v0), .data(dt0),
    .ready(ready0), .out_valid(ov0), .out_ready(ordy0),
    .out_data(od0), .beat_count(bcnt0), .overflow(ovf0),
    .protocol_err(err0)
  );

  handshake_slave #(
    .DATA_BITS(8), .ALWAYS_READY(1), .DEPTH(4)
  ) u_dut1 (
    .clk(clk), .rst(rst), .valid(v1), .data(dt1),
    .ready(ready1), .out_valid(ov1), .out_ready(ordy1),
    .out_data(od1), .beat_count(bcnt1), .overflow(ovf1),
    .protocol_err(err1)
  );

  initial begin
    clk = 1'b0;
    #2;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) if (rst) seen1 = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      chk("rdy0", 32'(ready0), 32'(q0.size() < 4));
      chk("ov0", 32'(ov0), 32'(q0.size() != 0));
      chk("bc0", 32'(bcnt0), 32'(bc0));
      chk("ovf0", 32'(ovf0), 32'(0));
      chk("perr0", 32'(err0), 32'(perr0));
      if (ov0 && ordy0 && q0.size() != 0) begin
        chk("dat0", 32'(od0), 32'(q0.pop_front()));
        npop0++;
      end
      if (v0 && ready0) begin
        q0.push_back(dt0);
        bc0 = bc0 + 16'd1;
      end
      if (PCHK && pend0 && (!v0 || dt0 != pd0)) perr0 = 1'b1;
      pend0 = v0 && !ready0;
      pd0   = dt0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rdy1", 32'(ready1), 32'(seen1));
      chk("ov1", 32'(ov1), 32'(q1.size() != 0));
      chk("bc1", 32'(bcnt1), 32'(bc1));
      chk("ovf1", 32'(ovf1), 32'(ovf1e));
      chk("perr1", 32'(err1), 32'(perr1));
      if (ov1 && ordy1 && q1.size() != 0) begin
        chk("dat1", 32'(od1), 32'(q1.pop_front()));
        npop1++;
      end
      if (v1 && ready1) begin
        bc1 = bc1 + 16'd1;
        if (q1.size() < 4) q1.push_back(dt1);
        else ovf1e = 1'b1;
      end
      if (PCHK && pend1 && (!v1 || dt1 != pd1)) perr1 = 1'b1;
      pend1 = v1 && !ready1;
      pd1   = dt1;
    end
  end

  task automatic rst_chk(input string tag);
    chk({tag, "_rdy0"}, 32'(ready0), 32'(0));
    chk({tag, "_ov0"}, 32'(ov0), 32'(0));
    chk({tag, "_bc0"}, 32'(bcnt0), 32'(0));
    chk({tag, "_ovf0"}, 32'(ovf0), 32'(0));
    chk({tag, "_err0"}, 32'(err0), 32'(0));
    chk({tag, "_rdy1"}, 32'(ready1), 32'(0));
    chk({tag, "_ov1"}, 32'(ov1), 32'(0));
    chk({tag, "_bc1"}, 32'(bcnt1), 32'(0));
    chk({tag, "_ovf1"}, 32'(ovf1), 32'(0));
    chk({tag, "_err1"}, 32'(err1), 32'(0));
  endtask

  task automatic clr_model();
    q0.delete();
    q1.delete();
    bc0 = '0; bc1 = '0;
    ovf1e = 1'b0; perr0 = 1'b0; perr1 = 1'b0;
    pend0 = 1'b0; pend1 = 1'b0; seen1 = 1'b0;
    pd0 = '0; pd1 = '0;
    npop0 = 0; npop1 = 0;
  endtask

  task automatic do_reset(input bit now);
    if (now) #1;
    else begin
      @(posedge clk);
      #2;
    end
    rst = 1'b0;
    #1;
    rst_chk("rst");
    clr_model();
    v0 = 1'b0; v1 = 1'b0;
    ordy0 = 1'b0; ordy1 = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  task automatic beat0(input logic [7:0] d);
    v0 = 1'b1; dt0 = d;
    tick();
  endtask

  task automatic beat1(input logic [7:0] d);
    v1 = 1'b1; dt1 = d;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    v0 = 1'b0; dt0 = '0; ordy0 = 1'b0;
    v1 = 1'b0; dt1 = '0; ordy1 = 1'b0;
    clr_model();
    #50;
    rst_chk("init");
    #50;
    rst = 1'b1;

    // registered ready, two beats streamed through
    ordy1 = 1'b1;
    tick();
    beat1(8'hA5);
    beat1(8'hC4);
    v1 = 1'b0;
    repeat (4) tick();
    chk("t1_bc", 32'(bcnt1), 32'(2));
    chk("t1_ovf", 32'(ovf1), 32'(0));
    chk("t1_np", 32'(npop1), 32'(2));

    // combinational ready, back-pressure after four beats
    do_reset(1'b0);
    for (int i = 1; i <= 4; i++) beat0(8'(i));
    v0 = 1'b1; dt0 = 8'd5;
    repeat (3) tick();
    chk("t2_rdy", 32'(ready0), 32'(0));
    chk("t2_bc", 32'(bcnt0), 32'(4));
    v0 = 1'b0;
    ordy0 = 1'b1;
    repeat (6) tick();
    chk("t2_np", 32'(npop0), 32'(4));
    chk("t2_ov", 32'(ov0), 32'(0));

    // registered ready, fifth beat overflows
    do_reset(1'b0);
    tick();
    for (int i = 1; i <= 5; i++) beat1(8'(i));
    v1 = 1'b0;
    tick();
    chk("t3_ovf", 32'(ovf1), 32'(1));
    chk("t3_bc", 32'(bcnt1), 32'(5));
    ordy1 = 1'b1;
    repeat (6) tick();
    chk("t3_np", 32'(npop1), 32'(4));

    // full FIFO, push and pop together
    do_reset(1'b0);
    tick();
    for (int i = 1; i <= 4; i++) beat1(8'(i));
    ordy1 = 1'b1;
    beat1(8'h66);
    ordy1 = 1'b0;
    chk("t4_ovf", 32'(ovf1), 32'(0));
    beat1(8'h77);
    v1 = 1'b0;
    tick();
    chk("t4_full", 32'(ovf1), 32'(1));
    ordy1 = 1'b1;
    repeat (6) tick();
    chk("t4_np", 32'(npop1), 32'(5));

    // reset in the middle of a burst
    do_reset(1'b0);
    beat0(8'd1);
    beat0(8'd2);
    v0 = 1'b1; dt0 = 8'd3;
    do_reset(1'b1);
    repeat (2) tick();
    chk("t5_ov", 32'(ov0), 32'(0));
    chk("t5_bc", 32'(bcnt0), 32'(0));

    // data changed while stalled
    do_reset(1'b0);
    for (int i = 1; i <= 4; i++) beat0(8'(i));
    v0 = 1'b1; dt0 = 8'h11;
    repeat (2) tick();
    dt0 = 8'h22;
    repeat (2) tick();
    chk("t6_err", 32'(err0), 32'(PCHK));
    v0 = 1'b0;
    repeat (3) tick();
    chk("t6_stk", 32'(err0), 32'(PCHK));
    chk("t6_err1", 32'(err1), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
